// File: rtl/mc_rv32_core.sv
// mc_rv32_core: multi-cycle RV32I-subset core on one shared req/ack memory port.
// A FETCH/DECODE/EXEC/MEM/WB walk; any fault parks the core in HALT until reset.
module mc_rv32_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic [2:0]        state,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        err
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6f;
    localparam logic [6:0] OP_LUI = 7'h37;
    localparam logic [15:0] WLIM  = 16'(MAX_WAIT > 0 ? MAX_WAIT - 1 : 0);

    state_t cur, nxt;
    logic        run;
    logic [15:0] wcnt;
    logic [31:0] rf [32];
    logic [31:0] opa, opb, imm, res, maddr;

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui, legal;
    logic [31:0] imm_dec, op2, alu_y, agen, pc4, pct, wdat;
    logic        taken, misal, xfer, tmo, wen;

    assign opc = inst[6:0];
    assign rd  = inst[11:7];
    assign f3  = inst[14:12];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    assign is_r   = opc == OP_R;
    assign is_i   = opc == OP_I;
    assign is_ld  = opc == OP_LD;
    assign is_st  = opc == OP_ST;
    assign is_br  = opc == OP_BR;
    assign is_jal = opc == OP_JAL;
    assign is_lui = opc == OP_LUI;
    assign legal  = is_r | is_i | is_ld | is_st | is_br | is_jal | is_lui;

    always_comb begin
        imm_dec = {{20{inst[31]}}, inst[31:20]};
        unique case (1'b1)
            is_st:  imm_dec = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            is_br:  imm_dec = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            is_jal: imm_dec = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            is_lui: imm_dec = {inst[31:12], 12'b0};
            default: ;
        endcase
    end

    assign op2 = is_r ? opb : imm;

    always_comb begin
        alu_y = '0;
        unique case (f3)
            3'd0: alu_y = (is_r & inst[30]) ? opa - op2 : opa + op2;
            3'd1: alu_y = opa << op2[4:0];
            3'd2: alu_y = {31'b0, $signed(opa) < $signed(op2)};
            3'd3: alu_y = {31'b0, opa < op2};
            3'd4: alu_y = opa ^ op2;
            3'd5: alu_y = inst[30] ? 32'($signed(opa) >>> op2[4:0]) : opa >> op2[4:0];
            3'd6: alu_y = opa | op2;
            3'd7: alu_y = opa & op2;
        endcase
    end

    assign agen  = opa + imm;
    assign misal = agen[1:0] != 2'b00;
    assign pc4   = pc + 32'd4;
    assign pct   = pc + imm;
    assign taken = is_jal | (is_br & ((opa == opb) ^ inst[12]));

    // run keeps the port quiet for the first cycle after reset release
    assign mem_req   = run && (cur == S_FETCH || cur == S_MEM);
    assign mem_we    = (cur == S_MEM) && is_st;
    assign mem_addr  = (cur == S_FETCH) ? pc[ADDR_W-1:0] : maddr[ADDR_W-1:0];
    assign mem_wdata = opb;

    assign xfer = mem_req && mem_ack;
    assign tmo  = (MAX_WAIT > 0) && mem_req && !mem_ack && (wcnt == WLIM);

    assign state  = cur;
    assign halted = cur == S_HALT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        unique case (cur)
            S_FETCH: begin
                if (xfer)     nxt = S_DECODE;
                else if (tmo) nxt = S_HALT;
            end
            S_DECODE: nxt = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_ld || is_st) begin
                    nxt = misal ? S_HALT : S_MEM;
                end else if (is_br || is_jal) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                if (xfer) begin
                    nxt    = is_ld ? S_WB : S_FETCH;
                    retire = !is_ld;
                end else if (tmo) begin
                    nxt = S_HALT;
                end
            end
            S_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default: nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            wcnt  <= '0;
            pc    <= RESET_PC;
            inst  <= '0;
            err   <= 2'd0;
            opa   <= '0;
            opb   <= '0;
            imm   <= '0;
            res   <= '0;
            maddr <= '0;
        end else begin
            run <= 1'b1;
            if (mem_req && !mem_ack) wcnt <= wcnt + 16'd1;
            else                     wcnt <= '0;
            case (cur)
                S_FETCH: begin
                    if (xfer)     inst <= mem_rdata;
                    else if (tmo) err  <= 2'd3;
                end
                S_DECODE: begin
                    opa <= rf[rs1];
                    opb <= rf[rs2];
                    imm <= imm_dec;
                    if (!legal) err <= 2'd1;
                end
                S_EXEC: begin
                    res   <= is_lui ? imm : alu_y;
                    maddr <= agen;
                    if ((is_ld || is_st) && misal) err <= 2'd2;
                    if (is_br || is_jal) pc <= taken ? pct : pc4;
                end
                S_MEM: begin
                    if (xfer) begin
                        if (is_ld) res <= mem_rdata;
                        else       pc  <= pc4;
                    end else if (tmo) begin
                        err <= 2'd3;
                    end
                end
                S_WB: pc <= pc4;
                default: ;
            endcase
        end
    end

    assign wen  = (cur == S_WB) || (cur == S_EXEC && is_jal);
    assign wdat = (cur == S_WB) ? res : pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wen && rd != 5'd0) begin
            rf[rd] <= wdat;
        end
    end
endmodule

// File: tb/tb_mc_rv32_core.sv
// tb_mc_rv32_core: directed and random programs against an instruction-level model.
// Memory responder inserts fixed or random wait states on the req/ack port.
module tb_mc_rv32_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] pc, inst;
    logic [2:0]  state;
    logic        retire, halted;
    logic [1:0]  err;

    always #5 clk = ~clk;

    mc_rv32_core #(
        .RESET_PC(32'h0),
        .ADDR_W  (32),
        .MAX_WAIT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .pc       (pc),
        .inst     (inst),
        .state    (state),
        .retire   (retire),
        .halted   (halted),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] bmem [256];
    logic [31:0] prog [$];
    int fdly = 0;
    int ddly = 0;
    int wc = 0;
    int cur_dly = 0;

    function automatic int pick(input int d);
        return (d < 0) ? int'($urandom_range(0, 3)) : d;
    endfunction

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
                wc = 0;
            end else begin
                if (wc == 0) cur_dly = pick(state == 3'd0 ? fdly : ddly);
                if (wc >= cur_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr[9:2]];
                    if (mem_we) bmem[mem_addr[9:2]] = mem_wdata;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
    end

    function automatic logic [31:0] r_t(input int f7, rs2, rs1, f3, rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] i_t(input int im, rs1, f3, rd, op);
        return {12'(im), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] s_t(input int im, rs2, rs1);
        logic [11:0] m;
        m = 12'(im);
        return {m[11:5], 5'(rs2), 5'(rs1), 3'd2, m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input int im, rs2, rs1, f3);
        logic [12:0] m;
        m = 13'(im);
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input int im, rd);
        logic [20:0] m;
        m = 21'(im);
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] u_t(input int im, rd);
        return {20'(im), 5'(rd), 7'h37};
    endfunction

    // instruction-level model: architectural registers, memory image, pc
    logic [31:0] mr [32];
    logic [31:0] mm [256];
    logic [31:0] mpc;
    int          mcnt;

    function automatic logic [31:0] m_alu(input logic [2:0] f, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(int'(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic m_step(output bit st, output logic [31:0] sa, output logic [31:0] sd);
        logic [31:0] i, a, b, ii, is_, ib, ij, r, nx, ad;
        logic [4:0]  rd;
        logic [2:0]  f;
        bit          wr;
        i   = mm[mpc[9:2]];
        rd  = i[11:7];
        f   = i[14:12];
        a   = mr[i[19:15]];
        b   = mr[i[24:20]];
        ii  = {{20{i[31]}}, i[31:20]};
        is_ = {{20{i[31]}}, i[31:25], i[11:7]};
        ib  = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        ij  = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        nx  = mpc + 32'd4;
        st  = 0; sa = '0; sd = '0; wr = 0; r = '0;
        case (i[6:0])
            7'h33: begin wr = 1; r = m_alu(f, i[30], a, b); end
            7'h13: begin wr = 1; r = m_alu(f, (f == 3'd5) && i[30], a, ii); end
            7'h37: begin wr = 1; r = {i[31:12], 12'b0}; end
            7'h03: begin wr = 1; ad = a + ii; r = mm[ad[9:2]]; end
            7'h23: begin st = 1; sa = a + is_; sd = b; mm[sa[9:2]] = b; end
            7'h63: if ((a == b) != f[0]) nx = mpc + ib;
            7'h6f: begin wr = 1; r = mpc + 32'd4; nx = mpc + ij; end
            default: ;
        endcase
        if (wr && rd != 0) mr[rd] = r;
        mpc = nx;
        mcnt++;
    endtask

    function automatic logic [31:0] m_fault();
        logic [31:0] i, ad;
        i  = mm[mpc[9:2]];
        ad = '0;
        case (i[6:0])
            7'h33, 7'h13, 7'h37, 7'h63, 7'h6f: return 32'd0;
            7'h03: ad = mr[i[19:15]] + {{20{i[31]}}, i[31:20]};
            7'h23: ad = mr[i[19:15]] + {{20{i[31]}}, i[31:25], i[11:7]};
            default: return 32'd1;
        endcase
        return (ad[1:0] != 2'b00) ? 32'd2 : 32'd0;
    endfunction

    task automatic load_prog();
        for (int k = 0; k < 256; k++) bmem[k] = $urandom;
        foreach (prog[k]) bmem[k] = prog[k];
        bmem[prog.size()] = 32'h0;
    endtask

    int          rcyc [$];
    logic [31:0] rpc  [$];
    logic [31:0] stq  [$];

    task automatic run_prog(input int budget);
        int          cyc, first, nret;
        bit          pv_req, pv_ack, pv_we, dst, mst;
        logic [31:0] pv_addr, pv_wd, sa, sd, msa, msd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 32; k++) mr[k] = '0;
        for (int k = 0; k < 256; k++) mm[k] = bmem[k];
        mpc = '0; mcnt = 0;
        rcyc.delete(); rpc.delete(); stq.delete();
        rst = 1'b0;
        cyc = 0; first = -1; nret = 0;
        pv_req = 0; pv_ack = 0; pv_we = 0; pv_addr = '0; pv_wd = '0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            if (first < 0 && mem_req) first = cyc;
            if (pv_req && !pv_ack && mem_req) begin
                chk("hold_addr", mem_addr, pv_addr);
                chk("hold_we", mem_we, pv_we);
                if (pv_we) chk("hold_wdata", mem_wdata, pv_wd);
            end
            dst = mem_req && mem_ack && mem_we;
            sa  = mem_addr;
            sd  = mem_wdata;
            if (dst) begin
                stq.push_back(sd);
                chk("st_ret", retire, 1);
            end
            if (retire) begin
                rcyc.push_back(cyc - first + 1);
                rpc.push_back(pc);
                chk("pc", pc, mpc);
                m_step(mst, msa, msd);
                chk("st_flag", dst, mst);
                if (mst && dst) begin
                    chk("st_addr", sa, msa);
                    chk("st_data", sd, msd);
                end
                nret++;
            end
            pv_req = mem_req; pv_ack = mem_ack; pv_we = mem_we;
            pv_addr = mem_addr; pv_wd = mem_wdata;
        end
        chk("budget", cyc < budget, 1);
        chk("halted", halted, 1);
        chk("err", err, m_fault());
        chk("halt_pc", pc, mpc);
        chk("nret", nret, mcnt);
        repeat (3) @(negedge clk);
        #1;
        chk("halt_req", mem_req, 0);
    endtask

    task automatic gen_rand(input int n);
        int sel, rd, rs1, rs2, f3, im;
        prog.delete();
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 9);
            rd  = $urandom_range(1, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            f3  = $urandom_range(0, 7);
            case (sel)
                0, 1: prog.push_back(r_t(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                                         rs2, rs1, f3, rd));
                2, 3: begin
                    if (f3 == 3) f3 = 2;
                    im = $urandom_range(0, 4095);
                    if (f3 == 1) im = im & 31;
                    if (f3 == 5) im = (im & 31) | (($urandom_range(0, 1) == 1) ? 1024 : 0);
                    prog.push_back(i_t(im, rs1, f3, rd, 7'h13));
                end
                4: prog.push_back(u_t(int'($urandom), rd));
                5: prog.push_back(i_t(512 + 4 * $urandom_range(0, 63), 0, 2, rd, 7'h03));
                6: prog.push_back(s_t(512 + 4 * $urandom_range(0, 63), rs2, 0));
                7: prog.push_back(b_t(8, rs2, rs1, $urandom_range(0, 1)));
                8: prog.push_back(j_t(8, $urandom_range(0, 7)));
                default: prog.push_back(i_t($urandom_range(0, 4095), rs1, 0, rd, 7'h13));
            endcase
        end
        for (int r = 1; r < 8; r++) prog.push_back(s_t(768 + 4 * r, r, 0));
    endtask

    initial begin
        int n;
        // reset while a fetch is waiting
        prog = {i_t(5, 0, 0, 1, 7'h13)};
        load_prog();
        fdly = 100; ddly = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t1_req_pre", mem_req, 1);
        chk("t1_addr_pre", mem_addr, 0);
        #2 rst = 1'b1;
        #1;
        chk("t1_req_rst", mem_req, 0);
        chk("t1_pc_rst", pc, 0);
        chk("t1_state_rst", state, 0);
        chk("t1_inst_rst", inst, 0);
        chk("t1_ret_rst", retire, 0);
        chk("t1_halt_rst", halted, 0);
        chk("t1_err_rst", err, 0);
        fdly = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t1_req_rel", mem_req, 0);
        @(negedge clk);
        #1;
        chk("t1_req_up", mem_req, 1);
        chk("t1_addr_up", mem_addr, 0);

        // zero-wait ALU pair
        prog = {i_t(5, 0, 0, 1, 7'h13), 32'h00108133, s_t(512, 2, 0)};
        load_prog();
        fdly = 0; ddly = 0;
        run_prog(200);
        chk("t2_ret1", rcyc[0], 4);
        chk("t2_ret2", rcyc[1], 8);
        chk("t2_pc", rpc[2], 8);
        chk("t2_x2", stq[0], 10);

        // store then load with 3 data wait states
        prog = {i_t(5, 0, 0, 1, 7'h13), r_t(0, 1, 1, 0, 2), s_t(0, 2, 0),
                i_t(0, 0, 2, 3, 7'h03), s_t(512, 3, 0)};
        load_prog();
        fdly = 0; ddly = 3;
        run_prog(300);
        chk("t3_sw_lat", rcyc[2] - rcyc[1], 7);
        chk("t3_lw_lat", rcyc[3] - rcyc[2], 8);
        chk("t3_x3", stq[1], 10);

        // branches and jal
        prog = {i_t(5, 0, 0, 1, 7'h13), b_t(8, 1, 1, 0), i_t(1, 0, 0, 6, 7'h13),
                b_t(8, 1, 1, 1), j_t(8, 0), j_t(12, 0), j_t(-4, 5),
                i_t(1, 0, 0, 6, 7'h13), s_t(512, 5, 0), s_t(516, 6, 0)};
        load_prog();
        fdly = 0; ddly = 0;
        run_prog(300);
        chk("t4_beq_lat", rcyc[1] - rcyc[0], 3);
        chk("t4_beq_tgt", rpc[2], 12);
        chk("t4_bne_nt", rpc[3], 16);
        chk("t4_x5", stq[0], 28);
        chk("t4_x6", stq[1], 0);

        // illegal opcode and misaligned load
        prog = {32'hFFFF_FFFF};
        load_prog();
        run_prog(100);
        chk("t5_err1", err, 1);
        prog = {i_t(2, 0, 2, 3, 7'h03)};
        load_prog();
        run_prog(100);
        chk("t5_err2", err, 2);

        // fetch timeout, then ack on the last allowed cycle
        prog = {i_t(5, 0, 0, 1, 7'h13)};
        load_prog();
        fdly = 100;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (mem_req) n++;
        end
        chk("t6_req_cyc", n, 8);
        chk("t6_err3", err, 3);
        chk("t6_halt", halted, 1);
        fdly = 7;
        run_prog(300);
        chk("t6_ack8_ret", rcyc.size(), 1);
        chk("t6_ack8_lat", rcyc[0], 11);

        // random programs with random wait states
        for (int t = 0; t < 8; t++) begin
            gen_rand(60);
            load_prog();
            fdly = -1; ddly = -1;
            run_prog(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
